ray_probe_reader: RTL

Read-side companion to the pixel plotter: the plotter writes trail pixels into the 160x120, 3-bit-colour framebuffer, and this block reads them back. On request it walks a straight line of up to 15 pixels from a player's head position in one of four directions. It reports the first occupied pixel or screen-edge wall, giving game logic collision and look-ahead information without disturbing the VGA write path.

---
 rtl/ray_probe_reader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ray_probe_reader.sv
// Framebuffer line probe: walks up to 15 pixels from a head position in one of
// four directions and reports the first occupied pixel or the screen-edge wall.
module ray_probe_reader #(
    parameter int XMAX = 160,
    parameter int YMAX = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [7:0]  x_in,
    input  logic [6:0]  y_in,
    input  logic [1:0]  dir,
    input  logic [3:0]  len,
    output logic        busy,
    output logic        done,
    output logic        hit,
    output logic        wall,
    output logic [3:0]  hit_dist,
    output logic [2:0]  hit_color,
    output logic [14:0] mem_addr,
    output logic        mem_rd,
    input  logic [2:0]  mem_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic signed [9:0] XLIM = 10'(XMAX);
    localparam logic signed [9:0] YLIM = 10'(YMAX);

    state_t      state;
    logic [7:0]  start_x;
    logic [6:0]  start_y;
    logic [1:0]  start_dir;
    logic [3:0]  probe_len;
    logic [3:0]  step;
    logic        step_oob;

    // Coordinate of the step about to enter ADDR. It is evaluated one cycle
    // early so mem_addr/mem_rd can be registered and still be visible in ADDR.
    logic [7:0]        base_x;
    logic [6:0]        base_y;
    logic [1:0]        base_dir;
    logic [3:0]        next_step;
    logic signed [9:0] probe_x;
    logic signed [9:0] probe_y;
    logic              probe_oob;
    logic [14:0]       probe_addr;

    always_comb begin
        base_x    = (state == IDLE) ? x_in : start_x;
        base_y    = (state == IDLE) ? y_in : start_y;
        base_dir  = (state == IDLE) ? dir  : start_dir;
        next_step = (state == IDLE) ? 4'd1 : step + 4'd1;
        probe_x   = signed'({2'b00, base_x});
        probe_y   = signed'({3'b000, base_y});
        case (base_dir)
            2'b00:   probe_x = probe_x + signed'({6'd0, next_step});
            2'b01:   probe_y = probe_y + signed'({6'd0, next_step});
            2'b10:   probe_x = probe_x - signed'({6'd0, next_step});
            default: probe_y = probe_y - signed'({6'd0, next_step});
        endcase
        probe_oob = (probe_x < 10'sd0) || (probe_x >= XLIM) ||
                    (probe_y < 10'sd0) || (probe_y >= YLIM);
        // y*160 + x as shift-and-add
        probe_addr = {1'b0, probe_y[6:0], 7'b0}
                   + {3'b0, probe_y[6:0], 5'b0}
                   + {7'b0, probe_x[7:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            start_x   <= '0;
            start_y   <= '0;
            start_dir <= '0;
            probe_len <= '0;
            step      <= '0;
            step_oob  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit       <= 1'b0;
            wall      <= 1'b0;
            hit_dist  <= '0;
            hit_color <= '0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    mem_rd <= 1'b0;
                    if (req) begin
                        start_x   <= x_in;
                        start_y   <= y_in;
                        start_dir <= dir;
                        probe_len <= len;
                        step      <= 4'd1;
                        hit       <= 1'b0;
                        wall      <= 1'b0;
                        hit_dist  <= '0;
                        hit_color <= '0;
                        busy      <= 1'b1;
                        if (len == 4'd0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            step_oob <= probe_oob;
                            if (!probe_oob) begin
                                mem_addr <= probe_addr;
                                mem_rd   <= 1'b1;
                            end
                            state <= ADDR;
                        end
                    end
                end

                ADDR: begin
                    mem_rd <= 1'b0;
                    if (step_oob) begin
                        hit       <= 1'b1;
                        wall      <= 1'b1;
                        hit_dist  <= step;
                        hit_color <= '0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    if (mem_data != 3'b000) begin
                        hit       <= 1'b1;
                        hit_dist  <= step;
                        hit_color <= mem_data;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (step == probe_len) begin
                        hit_dist <= probe_len;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        step     <= next_step;
                        step_oob <= probe_oob;
                        if (!probe_oob) begin
                            mem_addr <= probe_addr;
                            mem_rd   <= 1'b1;
                        end
                        state <= ADDR;
                    end
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
